byte_serializer: RTL and testbench



---
 rtl/byte_serializer.sv | 198 +++++++++++++++++++
 tb/tb_byte_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial transmit stage.
// Accepts bytes over valid/ready and shifts each out MSB-first on
// ser_data_out with ser_write_out held high for the whole byte, followed
// by an idle gap. Bit timing comes from an internal clock_1M divider.
//
// Optional feature: define SERIALIZER_SKID_EN to add a one-entry holding
// register so a byte can be accepted while the previous one is still
// being shifted or the gap is running. Without the macro, ready_out is
// only high in IDLE.
//
// Parameters:
//   CLK_DIV    clock_1M cycles per serial bit (2..255)
//   GAP_CYCLES idle cycles with the strobe low between bytes (1..255)

module byte_serializer #(
    parameter int CLK_DIV    = 10,
    parameter int GAP_CYCLES = 10
) (
    input  logic       clock_1M,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       hold_in,
    output logic       ser_data_out,
    output logic       ser_write_out,
    output logic       busy_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Terminal counts for the shared divider/gap counter.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;

    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [7:0] div_cnt;

    logic       xfer;
    logic       launch;
    logic [7:0] launch_byte;

    logic       div_tc;
    logic       gap_tc;
    logic       last_bit;

    logic       ser_data_nxt;
    logic       ser_write_nxt;

    assign div_tc   = (div_cnt == DIV_LAST);
    assign gap_tc   = (div_cnt == GAP_LAST);
    assign last_bit = (bit_cnt == 3'd7);

`ifdef SERIALIZER_SKID_EN
    logic       hold_full;
    logic [7:0] hold_data;
    logic       store;

    // Acceptance depends only on holding-register occupancy; the stored
    // byte always goes out before a freshly offered one.
    assign ready_out   = !reset && !hold_full;
    assign xfer        = valid_in && ready_out;
    assign launch      = (state == IDLE) && !hold_in && (hold_full || xfer);
    assign launch_byte = hold_full ? hold_data : byte_in;
    // A transferred byte bypasses the holding register only when it is
    // launched straight from IDLE with nothing stored ahead of it.
    assign store       = xfer && !(launch && !hold_full);

    // Holding register occupancy flag.
    always_ff @(posedge clock_1M or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (store) begin
            hold_full <= 1'b1;
        end else if (launch && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    // Holding register payload; only meaningful while hold_full is set.
    always_ff @(posedge clock_1M) begin
        if (store) begin
            hold_data <= byte_in;
        end
    end
`else
    // No buffering: a byte can only be taken when a launch is possible.
    assign ready_out   = !reset && (state == IDLE) && !hold_in;
    assign xfer        = valid_in && ready_out;
    assign launch      = xfer;
    assign launch_byte = byte_in;
`endif

    assign busy_out = (state != IDLE);

    // State register.
    always_ff @(posedge clock_1M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a byte always runs to completion once in SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (div_tc && last_bit) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_tc) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; the values are registered one edge later.
    always_comb begin
        ser_write_nxt = 1'b0;
        ser_data_nxt  = 1'b0;
        if (state == SHIFT) begin
            ser_write_nxt = 1'b1;
            ser_data_nxt  = shreg[7];
        end
    end

    // Registered serial outputs, cleared asynchronously by reset.
    always_ff @(posedge clock_1M or posedge reset) begin
        if (reset) begin
            ser_write_out <= 1'b0;
            ser_data_out  <= 1'b0;
        end else begin
            ser_write_out <= ser_write_nxt;
            ser_data_out  <= ser_data_nxt;
        end
    end

    // Divider and bit counter; the divider doubles as the gap timer.
    always_ff @(posedge clock_1M or posedge reset) begin
        if (reset) begin
            div_cnt <= 8'd0;
            bit_cnt <= 3'd0;
        end else begin
            case (state)
                SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= 8'd0;
                        bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        div_cnt <= 8'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    div_cnt <= 8'd0;
                    bit_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Shift register: load on launch, shift left at each bit boundary.
    always_ff @(posedge clock_1M) begin
        if (launch) begin
            shreg <= launch_byte;
        end else if ((state == SHIFT) && div_tc) begin
            shreg <= {shreg[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Testbench for byte_serializer: default-parameter instance plus a
// CLK_DIV=2 / GAP_CYCLES=1 instance. Expected waveforms are computed per
// cycle from the byte value and the bit/gap timing rules.

module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] a_byte;
    logic       a_valid;
    logic       a_ready;
    logic       a_hold;
    logic       a_data;
    logic       a_write;
    logic       a_busy;

    logic [7:0] b_byte;
    logic       b_valid;
    logic       b_ready;
    logic       b_hold;
    logic       b_data;
    logic       b_write;
    logic       b_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    byte_serializer #(.CLK_DIV(10), .GAP_CYCLES(10)) dut (
        .clock_1M     (clk),
        .reset        (rst),
        .byte_in      (a_byte),
        .valid_in     (a_valid),
        .ready_out    (a_ready),
        .hold_in      (a_hold),
        .ser_data_out (a_data),
        .ser_write_out(a_write),
        .busy_out     (a_busy)
    );

    byte_serializer #(.CLK_DIV(2), .GAP_CYCLES(1)) dut_b (
        .clock_1M     (clk),
        .reset        (rst),
        .byte_in      (b_byte),
        .valid_in     (b_valid),
        .ready_out    (b_ready),
        .hold_in      (b_hold),
        .ser_data_out (b_data),
        .ser_write_out(b_write),
        .busy_out     (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte and wait (bounded) until the next edge will transfer it.
    task automatic offer(input bit sel, input logic [7:0] val);
        int waited = 0;
        if (sel) begin b_byte = val; b_valid = 1'b1; end
        else     begin a_byte = val; a_valid = 1'b1; end
        while (!(sel ? b_ready : a_ready) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("offer_wait", (waited < 2000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Check one byte frame cycle by cycle starting at the transfer edge.
    // mode 0: drop valid; mode 1: keep valid and present nxt (back-to-back);
    // mode 2: skid sequence (nxt offered at once, then a third byte).
    task automatic stream(input bit sel, input logic [7:0] val, input int d, input int g,
                          input int mode, input logic [7:0] nxt, output int rise);
        logic w, dt, bz, rd;
        logic ew, ed, eb, er;
        rise = -1;
        for (int n = 0; n <= 8 * d + g; n++) begin
            @(negedge clk);
            if (n == 0) begin
                if (mode == 0) begin
                    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
                end else begin
                    if (sel) b_byte = nxt; else a_byte = nxt;
                end
            end
            if (mode == 2 && n == 1) a_byte = 8'h99;
            if (mode == 2 && n == 2) a_valid = 1'b0;
            w  = sel ? b_write : a_write;
            dt = sel ? b_data  : a_data;
            bz = sel ? b_busy  : a_busy;
            rd = sel ? b_ready : a_ready;
            ew = (n >= 1) && (n <= 8 * d);
            ed = 1'b0;
            if (ew) ed = val[7 - (n - 1) / d];
            eb = (n < 8 * d + g);
`ifdef SERIALIZER_SKID_EN
            er = (mode == 2) ? (n == 0) : 1'b1;
`else
            er = (n == 8 * d + g);
`endif
            chk("strobe", {31'd0, w}, {31'd0, ew});
            chk("data",   {31'd0, dt}, {31'd0, ed});
            chk("busy",   {31'd0, bz}, {31'd0, eb});
            chk("ready",  {31'd0, rd}, {31'd0, er});
            if (n == 1) rise = cyc;
        end
    endtask

    initial begin
        int r1, r2, bad;
        logic [7:0] v;

        rst = 1'b1;
        a_byte = 8'hAA; a_valid = 1'b1; a_hold = 1'b0;
        b_byte = 8'h00; b_valid = 1'b0; b_hold = 1'b0;

        // Reset: outputs low, ready gated off even with a byte offered.
        repeat (5) @(negedge clk);
        chk("rst_ready",   {31'd0, a_ready}, 32'd0);
        chk("rst_write",   {31'd0, a_write}, 32'd0);
        chk("rst_data",    {31'd0, a_data},  32'd0);
        chk("rst_busy",    {31'd0, a_busy},  32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_b_write", {31'd0, b_write}, 32'd0);
        a_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xAA.
        offer(1'b0, 8'hAA);
        stream(1'b0, 8'hAA, 10, 10, 0, 8'h00, r1);

`ifndef SERIALIZER_SKID_EN
        // Back-to-back with valid held high.
        offer(1'b0, 8'h55);
        stream(1'b0, 8'h55, 10, 10, 1, 8'hCC, r1);
        offer(1'b0, 8'hCC);
        stream(1'b0, 8'hCC, 10, 10, 0, 8'h00, r2);
        chk("b2b_spacing", r2 - r1, 32'd91);

        // Backpressure: nothing starts while hold_in is high.
        a_hold = 1'b1; a_byte = 8'h33; a_valid = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_ready || a_write) bad++;
        end
        chk("bp_stall", bad, 32'd0);
        a_hold = 1'b0;
        offer(1'b0, 8'h33);
        stream(1'b0, 8'h33, 10, 10, 0, 8'h00, r1);
`else
        // Skid: 0x11 launched, 0x22 buffered, third offer refused.
        offer(1'b0, 8'h11);
        stream(1'b0, 8'h11, 10, 10, 2, 8'h22, r1);
        stream(1'b0, 8'h22, 10, 10, 0, 8'h00, r2);
        chk("skid_spacing", r2 - r1, 32'd91);

        // Backpressure with buffering: byte parks, nothing goes out.
        a_hold = 1'b1;
        offer(1'b0, 8'h33);
        @(negedge clk);
        a_valid = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_ready || a_write) bad++;
        end
        chk("bp_stall", bad, 32'd0);
        a_hold = 1'b0;
        stream(1'b0, 8'h33, 10, 10, 0, 8'h00, r1);
`endif

        // Reset in the middle of bit 3 of 0xF0.
        offer(1'b0, 8'hF0);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (n == 0) a_valid = 1'b0;
        end
        chk("mid_write", {31'd0, a_write}, 32'd1);
        chk("mid_data",  {31'd0, a_data},  32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_write", {31'd0, a_write}, 32'd0);
        chk("mid_rst_data",  {31'd0, a_data},  32'd0);
        chk("mid_rst_busy",  {31'd0, a_busy},  32'd0);
        chk("mid_rst_ready", {31'd0, a_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        offer(1'b0, 8'h0F);
        stream(1'b0, 8'h0F, 10, 10, 0, 8'h00, r1);

        // Minimum-parameter instance.
        offer(1'b1, 8'h81);
        stream(1'b1, 8'h81, 2, 1, 0, 8'h00, r1);

        // Randomized bytes and idle spacing on both instances.
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            offer(1'b0, v);
            stream(1'b0, v, 10, 10, 0, 8'h00, r1);
        end
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            offer(1'b1, v);
            stream(1'b1, v, 2, 1, 0, 8'h00, r1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
